ddr4_axi_ctrl_write_master: RTL and testbench
=============================================

Name: ddr4_axi_ctrl_write_master

Overview:
AXI4-Lite write initiator that drives the controller's AXI-Lite register slave from internal logic, such as calibration or a debug sequencer.
- Accepts single-beat write commands (addr, data) over a valid/ready port.
- Issues the AW and W channels, waits for the B response, then reports completion and status.
- A watchdog counter aborts the transaction if the slave does not respond.

Parameters:
C_ADDR_WIDTH, 32, AXI-Lite address width
C_DATA_WIDTH, 32, AXI-Lite data width
C_TIMEOUT_WIDTH, 8, watchdog counter width; abort after 2^C_TIMEOUT_WIDTH-1 active cycles

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  write command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_addr  input  C_ADDR_WIDTH  target register address
cmd_data  input  C_DATA_WIDTH  write data
awvalid  output  1  AW valid
awready  input  1  AW ready
awaddr  output  C_ADDR_WIDTH  AW address (registered)
wvalid  output  1  W valid
wready  input  1  W ready
wdata  output  C_DATA_WIDTH  W data (registered)
wstrb  output  C_DATA_WIDTH/8  constant all-ones
bvalid  input  1  B valid
bready  output  1  B ready
bresp  input  2  B response
done  output  1  one-cycle pulse: transaction ended
done_resp  output  2  captured bresp, or 2'b10 on timeout; valid with done
timeout  output  1  one-cycle pulse, coincident with done, on watchdog abort
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values (effective at the next edge, including when asserted mid-transaction, with no completion reported):
  - state=IDLE; cmd_ready=1; awvalid=wvalid=bready=0; done=timeout=0; done_resp=2'b00; busy=0.
  - awaddr and wdata are don't-care.
- States: IDLE, ADDR_DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake: latch cmd_addr into awaddr and cmd_data into wdata; set awvalid=1 and wvalid=1 at the next edge; clear the watchdog; go to ADDR_DATA.
- ADDR_DATA:
  - cmd_ready=0.
  - awvalid holds until its own handshake (awvalid & awready), then clears. wvalid likewise clears on its own handshake.
  - The handshakes may occur in either order or in the same cycle. The slave is allowed to raise wready only after the AW handshake; the master must not wait for wready before asserting wvalid.
  - Once both handshakes are complete (including the cycle in which the last one occurs), go to RESP with bready=1.
  - awaddr and wdata are stable while their valid is high.
- RESP:
  - bready=1.
  - On bvalid & bready: capture bresp into done_resp; pulse done for the next cycle; drop bready; return to IDLE. cmd_ready=1 in that same next cycle.
- bvalid in ADDR_DATA is ignored: bready=0 there and no state effect.
- Watchdog:
  - Increments every cycle in ADDR_DATA or RESP.
  - At all-ones with no completing handshake that cycle: deassert awvalid, wvalid and bready; pulse done and timeout; done_resp=2'b10; go to IDLE.
  - This deliberate fault exit is the only case where a valid drops without a handshake.
  - If the completing handshake (B, or last AW/W) coincides with terminal count, the handshake wins and no timeout occurs.
- Back-to-back operation:
  - A new command can be accepted in the same cycle as the done pulse.
  - There is no internal queue: one outstanding transaction at most.
- Latency with a zero-wait slave (awready=1, wready one cycle after AW, bvalid one cycle after W):
  - cmd handshake at cycle N → AW handshake at N+1 → W handshake at N+2 → B handshake at N+3 → done at N+4.

Test Plan:
- Zero-wait slave; cmd addr=32'h0000_F004, data=32'hDEAD_BEEF at cycle 0 → awvalid/wvalid high at cycle 1, awaddr=F004, wdata=DEADBEEF; done at cycle 4 with done_resp=00; busy cycles 1-3.
- Slave with wready asserted before awready, then awready 3 cycles later → wvalid clears after its handshake; awvalid held with stable awaddr; RESP entered only after both handshakes; single done pulse.
- bresp=2'b10 returned with bvalid delayed 5 cycles → bready held high throughout; done_resp=10; timeout=0.
- Slave never asserts bvalid, C_TIMEOUT_WIDTH=4 → abort after 15 active cycles; done=timeout=1 for one cycle; done_resp=10; bready=0; cmd_ready=1 afterwards.
- Two back-to-back commands with cmd_valid held → second accepted in the cycle of the first done; awaddr updates to the second address with no idle gap beyond spec.
- reset asserted in RESP with bvalid pending → next cycle: all outputs at reset values, no done pulse; a subsequent command completes normally.

Source files
------------

// File: rtl/ddr4_axi_ctrl_write_master.sv
// ---------------------------------------------------------------------------
// ddr4_axi_ctrl_write_master
//
// AXI4-Lite single-beat write initiator. Internal agents such as calibration
// or a debug sequencer use it to write the controller's AXI-Lite register
// slave. A command (addr, data) is accepted over a valid/ready port. The
// block then issues AW and W, waits for B, and reports completion and the
// response. A watchdog aborts the transaction if the slave stops responding.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_addr, cmd_data    target register address and write data
//   awvalid/awready/awaddr  AXI-Lite write address channel
//   wvalid/wready/wdata/wstrb  AXI-Lite write data channel (wstrb all-ones)
//   bvalid/bready/bresp   AXI-Lite write response channel
//   done                  one-cycle pulse when a transaction ends
//   done_resp             captured bresp, or 2'b10 on watchdog abort
//   timeout               one-cycle pulse, coincident with done, on abort
//   busy                  high while a transaction is outstanding
// ---------------------------------------------------------------------------
module ddr4_axi_ctrl_write_master #(
    parameter int C_ADDR_WIDTH    = 32,
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_TIMEOUT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_data,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [C_ADDR_WIDTH-1:0]   awaddr,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [C_DATA_WIDTH-1:0]   wdata,
    output logic [C_DATA_WIDTH/8-1:0] wstrb,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp,
    output logic                      done,
    output logic [1:0]                done_resp,
    output logic                      timeout,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ADDR_DATA = 2'b01,
        ST_RESP      = 2'b10
    } state_t;

    localparam logic [C_TIMEOUT_WIDTH-1:0] WD_ZERO = {C_TIMEOUT_WIDTH{1'b0}};
    localparam logic [C_TIMEOUT_WIDTH-1:0] WD_ONE  = {{(C_TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_TIMEOUT_WIDTH-1:0] WD_TERM = {C_TIMEOUT_WIDTH{1'b1}};
    localparam logic [1:0]                 RESP_SLVERR = 2'b10;
    localparam logic [1:0]                 RESP_OKAY   = 2'b00;

    state_t                      state_r;
    logic                        cmd_ready_r;
    logic                        awvalid_r;
    logic                        wvalid_r;
    logic                        bready_r;
    logic                        done_r;
    logic                        timeout_r;
    logic                        busy_r;
    logic [1:0]                  done_resp_r;
    logic [C_ADDR_WIDTH-1:0]     awaddr_r;
    logic [C_DATA_WIDTH-1:0]     wdata_r;
    logic [C_TIMEOUT_WIDTH-1:0]  wd_r;

    logic                        cmd_hs_s;
    logic                        aw_done_s;
    logic                        w_done_s;
    logic                        addr_data_done_s;
    logic                        b_hs_s;
    logic [C_TIMEOUT_WIDTH-1:0]  wd_next_s;
    logic                        wd_term_s;

    // Handshake decode and watchdog terminal-count detection
    always_comb begin
        cmd_hs_s  = cmd_valid & cmd_ready_r;
        // A channel counts as finished if its valid already dropped, or if
        // it handshakes this cycle; this lets AW and W complete in any order.
        aw_done_s = ~awvalid_r | awready;
        w_done_s  = ~wvalid_r | wready;
        addr_data_done_s = aw_done_s & w_done_s;
        b_hs_s    = bready_r & bvalid;
        // The counter is cleared on accept and counts the active cycle it is
        // in, so reaching all-ones on this cycle's increment means exactly
        // 2^C_TIMEOUT_WIDTH-1 active cycles have elapsed.
        wd_next_s = wd_r + WD_ONE;
        wd_term_s = (wd_next_s == WD_TERM);
    end

    // Transaction FSM with registered channel controls and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_resp_r <= RESP_OKAY;
            wd_r        <= WD_ZERO;
        end else begin
            // Status pulses last one cycle unless re-armed below
            done_r    <= 1'b0;
            timeout_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (cmd_hs_s) begin
                        awaddr_r    <= cmd_addr;
                        wdata_r     <= cmd_data;
                        awvalid_r   <= 1'b1;
                        wvalid_r    <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        wd_r        <= WD_ZERO;
                        state_r     <= ST_ADDR_DATA;
                    end else begin
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end

                ST_ADDR_DATA: begin
                    wd_r <= wd_next_s;
                    // Completing handshake has priority over the watchdog
                    if (addr_data_done_s) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= ST_RESP;
                    end else if (wd_term_s) begin
                        // Fault exit: the only path where a valid drops
                        // without its handshake
                        awvalid_r   <= 1'b0;
                        wvalid_r    <= 1'b0;
                        bready_r    <= 1'b0;
                        done_r      <= 1'b1;
                        timeout_r   <= 1'b1;
                        done_resp_r <= RESP_SLVERR;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        // Each valid clears on its own handshake only
                        awvalid_r <= awvalid_r & ~awready;
                        wvalid_r  <= wvalid_r & ~wready;
                    end
                end

                ST_RESP: begin
                    wd_r <= wd_next_s;
                    if (b_hs_s) begin
                        bready_r    <= 1'b0;
                        done_r      <= 1'b1;
                        done_resp_r <= bresp;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (wd_term_s) begin
                        bready_r    <= 1'b0;
                        done_r      <= 1'b1;
                        timeout_r   <= 1'b1;
                        done_resp_r <= RESP_SLVERR;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        bready_r <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a clean idle state
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    bready_r    <= 1'b0;
                    busy_r      <= 1'b0;
                    wd_r        <= WD_ZERO;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign awvalid   = awvalid_r;
    assign awaddr    = awaddr_r;
    assign wvalid    = wvalid_r;
    assign wdata     = wdata_r;
    assign wstrb     = {(C_DATA_WIDTH/8){1'b1}};
    assign bready    = bready_r;
    assign done      = done_r;
    assign done_resp = done_resp_r;
    assign timeout   = timeout_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ddr4_axi_ctrl_write_master.sv
// ---------------------------------------------------------------------------
// Testbench for ddr4_axi_ctrl_write_master. A per-cycle vector table covers
// the zero-wait flow, out-of-order AW/W, and a delayed error response. Hand
// sequences cover back-to-back commands, watchdog abort, handshake at
// terminal count, and reset during RESP.
// ---------------------------------------------------------------------------
module tb_ddr4_axi_ctrl_write_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        done;
    logic [1:0]  done_resp;
    logic        timeout;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr4_axi_ctrl_write_master #(
        .C_ADDR_WIDTH   (32),
        .C_DATA_WIDTH   (32),
        .C_TIMEOUT_WIDTH(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .awvalid  (awvalid),
        .awready  (awready),
        .awaddr   (awaddr),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .bvalid   (bvalid),
        .bready   (bready),
        .bresp    (bresp),
        .done     (done),
        .done_resp(done_resp),
        .timeout  (timeout),
        .busy     (busy)
    );

    // Inputs applied during one cycle, and outputs expected in the next
    typedef struct {
        logic        cv;
        logic [31:0] ca;
        logic [31:0] cd;
        logic        awr;
        logic        wr;
        logic        bv;
        logic [1:0]  br;
        logic        e_cr;
        logic        e_aw;
        logic        e_w;
        logic        e_b;
        logic        e_done;
        logic [1:0]  e_resp;
        logic        e_to;
        logic        e_busy;
        logic [31:0] e_addr;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(
        input logic cv, input logic [31:0] ca, input logic [31:0] cd,
        input logic awr, input logic wr, input logic bv, input logic [1:0] br,
        input logic cr, input logic aw, input logic w, input logic b,
        input logic dn, input logic [1:0] rs, input logic to, input logic bz,
        input logic [31:0] ea, input logic [31:0] ed);
        vec_t v;
        v.cv = cv; v.ca = ca; v.cd = cd; v.awr = awr; v.wr = wr; v.bv = bv; v.br = br;
        v.e_cr = cr; v.e_aw = aw; v.e_w = w; v.e_b = b; v.e_done = dn;
        v.e_resp = rs; v.e_to = to; v.e_busy = bz; v.e_addr = ea; v.e_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic cv, input logic [31:0] ca, input logic [31:0] cd,
                          input logic awr, input logic wr, input logic bv, input logic [1:0] br);
        cmd_valid = cv; cmd_addr = ca; cmd_data = cd;
        awready = awr; wready = wr; bvalid = bv; bresp = br;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, ".awvalid"},   {31'd0, awvalid},   32'd0);
        chk({tag, ".wvalid"},    {31'd0, wvalid},    32'd0);
        chk({tag, ".bready"},    {31'd0, bready},    32'd0);
        chk({tag, ".done"},      {31'd0, done},      32'd0);
        chk({tag, ".timeout"},   {31'd0, timeout},   32'd0);
        chk({tag, ".busy"},      {31'd0, busy},      32'd0);
    endtask

    vec_t tbl[20];

    initial begin
        int act_cycles;
        int guard;
        string t;

        tbl[0]  = mk(1'b1, 32'h0000_F004, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 2'b00,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_F004, 32'hDEAD_BEEF);
        tbl[1]  = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_F004, 32'hDEAD_BEEF);
        tbl[2]  = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 2'b00,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        tbl[3]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        tbl[4]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        // W accepted first, AW three cycles later; stray bvalid in ADDR_DATA
        tbl[5]  = mk(1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 2'b00,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111);
        tbl[6]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        tbl[7]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b11,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        tbl[8]  = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00,
                     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        tbl[9]  = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        tbl[10] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0);
        // Both handshakes in one cycle, then SLVERR after five wait cycles
        tbl[11] = mk(1'b1, 32'h0000_0020, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 2'b00,
                     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0020, 32'h2222_2222);
        tbl[12] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 2'b00,
                     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        for (int i = 13; i < 18; i++) begin
            tbl[i] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00,
                        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
        end
        tbl[18] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b10,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0);
        tbl[19] = mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        reset = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        tick();
        chk_idle("reset");
        chk("reset.done_resp", {30'd0, done_resp}, 32'd0);
        chk("wstrb", {28'd0, wstrb}, 32'h0000_000F);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].cv, tbl[i].ca, tbl[i].cd, tbl[i].awr, tbl[i].wr, tbl[i].bv, tbl[i].br);
            tick();
            t = $sformatf("vec%0d", i);
            chk({t, ".cmd_ready"}, {31'd0, cmd_ready}, {31'd0, tbl[i].e_cr});
            chk({t, ".awvalid"},   {31'd0, awvalid},   {31'd0, tbl[i].e_aw});
            chk({t, ".wvalid"},    {31'd0, wvalid},    {31'd0, tbl[i].e_w});
            chk({t, ".bready"},    {31'd0, bready},    {31'd0, tbl[i].e_b});
            chk({t, ".done"},      {31'd0, done},      {31'd0, tbl[i].e_done});
            chk({t, ".timeout"},   {31'd0, timeout},   {31'd0, tbl[i].e_to});
            chk({t, ".busy"},      {31'd0, busy},      {31'd0, tbl[i].e_busy});
            if (tbl[i].e_done) chk({t, ".done_resp"}, {30'd0, done_resp}, {30'd0, tbl[i].e_resp});
            if (tbl[i].e_aw)   chk({t, ".awaddr"}, awaddr, tbl[i].e_addr);
            if (tbl[i].e_w)    chk({t, ".wdata"},  wdata,  tbl[i].e_data);
        end

        // Back-to-back: second command accepted in the cycle of the first done
        set_in(1'b1, 32'h0000_A000, 32'hAAAA_0001, 1'b1, 1'b1, 1'b1, 2'b00);
        tick();
        chk("b2b.c1.awaddr", awaddr, 32'h0000_A000);
        chk("b2b.c1.awvalid", {31'd0, awvalid}, 32'd1);
        cmd_addr = 32'h0000_B000;
        cmd_data = 32'hBBBB_0002;
        tick();
        chk("b2b.c2.bready", {31'd0, bready}, 32'd1);
        tick();
        chk("b2b.c3.done", {31'd0, done}, 32'd1);
        chk("b2b.c3.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("b2b.c3.done_resp", {30'd0, done_resp}, 32'd0);
        tick();
        chk("b2b.c4.awaddr", awaddr, 32'h0000_B000);
        chk("b2b.c4.wdata", wdata, 32'hBBBB_0002);
        chk("b2b.c4.awvalid", {31'd0, awvalid}, 32'd1);
        chk("b2b.c4.done", {31'd0, done}, 32'd0);
        chk("b2b.c4.busy", {31'd0, busy}, 32'd1);
        cmd_valid = 1'b0;
        bresp = 2'b11;
        tick();
        chk("b2b.c5.bready", {31'd0, bready}, 32'd1);
        tick();
        chk("b2b.c6.done", {31'd0, done}, 32'd1);
        chk("b2b.c6.done_resp", {30'd0, done_resp}, 32'd3);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        chk_idle("b2b.c7");

        // Watchdog abort: slave never returns B
        set_in(1'b1, 32'h0000_0030, 32'h3333_3333, 1'b1, 1'b1, 1'b0, 2'b00);
        tick();
        cmd_valid = 1'b0;
        act_cycles = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) act_cycles++;
            tick();
            guard++;
        end
        chk("wd.done", {31'd0, done}, 32'd1);
        chk("wd.active_cycles", act_cycles, 32'd15);
        chk("wd.timeout", {31'd0, timeout}, 32'd1);
        chk("wd.done_resp", {30'd0, done_resp}, 32'd2);
        chk("wd.bready", {31'd0, bready}, 32'd0);
        chk("wd.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk_idle("wd.after");

        // B handshake on the terminal-count cycle wins over the watchdog
        set_in(1'b1, 32'h0000_0034, 32'h4444_4444, 1'b1, 1'b1, 1'b0, 2'b00);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("hsw.pre.done", {31'd0, done}, 32'd0);
        chk("hsw.pre.bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        bresp  = 2'b01;
        tick();
        chk("hsw.done", {31'd0, done}, 32'd1);
        chk("hsw.timeout", {31'd0, timeout}, 32'd0);
        chk("hsw.done_resp", {30'd0, done_resp}, 32'd1);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
        tick();

        // Reset while in RESP with bvalid pending
        set_in(1'b1, 32'h0000_0040, 32'h5555_5555, 1'b1, 1'b1, 1'b0, 2'b00);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst.resp.bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        reset  = 1'b1;
        tick();
        chk_idle("rst");
        chk("rst.done_resp", {30'd0, done_resp}, 32'd0);
        reset  = 1'b0;
        bvalid = 1'b0;
        tick();
        chk("rst.after.done", {31'd0, done}, 32'd0);
        set_in(1'b1, 32'h0000_0044, 32'h6666_6666, 1'b1, 1'b1, 1'b1, 2'b01);
        tick();
        chk("rst.new.awaddr", awaddr, 32'h0000_0044);
        cmd_valid = 1'b0;
        guard = 0;
        while (!done && guard < 10) begin
            tick();
            guard++;
        end
        chk("rst.new.done", {31'd0, done}, 32'd1);
        chk("rst.new.done_resp", {30'd0, done_resp}, 32'd1);
        chk("rst.new.timeout", {31'd0, timeout}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
